// File: rtl/fetch_line_unit_pkg.sv
// rtl/fetch_line_unit_pkg.sv - shared fetch types: opcodes, queue entry, FSM states, immediate decode
package rv32cpu_type;

    localparam logic [6:0] op_b_jal = 7'b1101111;
    localparam logic [6:0] op_b_br  = 7'b1100011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [1:0]  br_predicted;
    } instr_queue_entry_t;

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} fetch_state_t;

    function automatic logic [31:0] imm_j(input logic [31:0] ir);
        return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_line_unit_predecode.sv
// rtl/fetch_line_unit_predecode.sv - combinational pre-decode and prediction of one fetched line
// Ports: line_pc_i (line base), start_mask_i, line_i, bp_valid_i/bp_counter_i in;
//        mask_o, offset_o, br_en_o, taken_o, next_pc_o, br_predicted_o out.
module fetch_predecode
    import rv32cpu_type::*;
#(
    parameter int  FETCH_WIDTH = 8,
    localparam int OFS_W       = $clog2(FETCH_WIDTH)
) (
    input  logic [31:0]               line_pc_i,
    input  logic [FETCH_WIDTH-1:0]    start_mask_i,
    input  logic [32*FETCH_WIDTH-1:0] line_i,
    input  logic                      bp_valid_i,
    input  logic [1:0]                bp_counter_i,
    output logic [FETCH_WIDTH-1:0]    mask_o,
    output logic [OFS_W-1:0]          offset_o,
    output logic                      br_en_o,
    output logic                      taken_o,
    output logic [31:0]               next_pc_o,
    output logic [1:0]                br_predicted_o
);

    localparam logic [31:0] LINE_BYTES = 32'(4 * FETCH_WIDTH);

    logic        found;
    logic [31:0] ir;
    logic [31:0] win_ir;
    logic        is_jal;
    logic        is_br;
    logic        pred_taken;
    logic [31:0] slot_pc;

    always_comb begin
        mask_o         = '0;
        offset_o       = '0;
        found          = 1'b0;
        ir             = '0;
        win_ir         = '0;
        // Slots are kept up to and including the first control-flow
        // instruction; everything after it is on the wrong path.
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            ir        = line_i[32*i +: 32];
            mask_o[i] = start_mask_i[i] & ~found;
            if (start_mask_i[i] && !found && (ir[6:0] == op_b_jal || ir[6:0] == op_b_br)) begin
                found    = 1'b1;
                offset_o = OFS_W'(i);
                win_ir   = ir;
            end
        end

        is_jal     = found && (win_ir[6:0] == op_b_jal);
        is_br      = found && (win_ir[6:0] == op_b_br);
        pred_taken = bp_valid_i ? bp_counter_i[1] : win_ir[31];
        slot_pc    = line_pc_i + 32'({offset_o, 2'b00});

        br_en_o        = is_br;
        taken_o        = is_jal | (is_br & pred_taken);
        br_predicted_o = '0;
        if (is_br) begin
            br_predicted_o = bp_valid_i ? bp_counter_i : {win_ir[31], ~win_ir[31]};
        end

        if (is_jal) begin
            next_pc_o = slot_pc + imm_j(win_ir);
        end else if (is_br) begin
            next_pc_o = pred_taken ? slot_pc + imm_b(win_ir) : slot_pc + 32'd4;
        end else begin
            next_pc_o = line_pc_i + LINE_BYTES;
        end
    end

endmodule

// File: rtl/fetch_line_unit.sv
// rtl/fetch_line_unit.sv - line fetch stage: request FSM, line buffer, pre-decode and redirect
// Ports: clk, rst (async high); fe_stall_i, fe_flush_i, fe_flush_pc_i from backend/queue;
//        imem_req_o/imem_addr_o/imem_resp_i/imem_data_i to I-cache; bp_valid_i/bp_counter_i;
//        iq_enqueue_o/iq_mask_o/iq_entry_o, br_en_o, fetch_pc_offset_o to the instruction queue.
// Optional macro FETCH_PERF_EN adds perf_lines_o, perf_redirects_o, perf_stall_o counters.
module fetch_line_unit
    import rv32cpu_type::*;
#(
    parameter int          FETCH_WIDTH = 8,
    parameter logic [31:0] RESET_PC    = 32'haaaaa000,
    localparam int         OFS_W       = $clog2(FETCH_WIDTH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  fe_stall_i,
    input  logic                                  fe_flush_i,
    input  logic [31:0]                           fe_flush_pc_i,
    output logic                                  imem_req_o,
    output logic [31:0]                           imem_addr_o,
    input  logic                                  imem_resp_i,
    input  logic [32*FETCH_WIDTH-1:0]             imem_data_i,
    input  logic                                  bp_valid_i,
    input  logic [1:0]                            bp_counter_i,
    output logic                                  iq_enqueue_o,
    output logic [FETCH_WIDTH-1:0]                iq_mask_o,
    output instr_queue_entry_t [FETCH_WIDTH-1:0]  iq_entry_o,
    output logic                                  br_en_o,
    output logic [OFS_W-1:0]                      fetch_pc_offset_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                           perf_lines_o,
    output logic [31:0]                           perf_redirects_o,
    output logic [31:0]                           perf_stall_o
`endif
);

    localparam logic [31:0] LINE_MASK = 32'(4 * FETCH_WIDTH - 1);

    fetch_state_t              state_q, state_d;
    logic [31:0]               pc_q, pc_d;
    logic [32*FETCH_WIDTH-1:0] line_q, line_d;
    logic                      valid_q, valid_d;

    logic [31:0]               line_base;
    logic [FETCH_WIDTH-1:0]    start_mask;
    logic                      offer;
    logic [FETCH_WIDTH-1:0]    pd_mask;
    logic [OFS_W-1:0]          pd_offset;
    logic                      pd_br_en;
    logic                      pd_taken;
    logic [31:0]               pd_next_pc;
    logic [1:0]                pd_br_predicted;

    assign line_base  = pc_q & ~LINE_MASK;
    assign start_mask = {FETCH_WIDTH{1'b1}} << pc_q[OFS_W+1:2];
    assign offer      = (state_q == HOLD) && valid_q;

    fetch_predecode #(.FETCH_WIDTH(FETCH_WIDTH)) u_predecode (
        .line_pc_i      (line_base),
        .start_mask_i   (start_mask),
        .line_i         (line_q),
        .bp_valid_i     (bp_valid_i),
        .bp_counter_i   (bp_counter_i),
        .mask_o         (pd_mask),
        .offset_o       (pd_offset),
        .br_en_o        (pd_br_en),
        .taken_o        (pd_taken),
        .next_pc_o      (pd_next_pc),
        .br_predicted_o (pd_br_predicted)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        line_d       = line_q;
        valid_d      = valid_q;
        // A flush in REQ withholds the strobe so the old-path request is never issued.
        imem_req_o   = (state_q == REQ) && !rst && !fe_flush_i;
        iq_enqueue_o = offer && !fe_stall_i && !fe_flush_i;

        if (fe_flush_i) begin
            pc_d    = fe_flush_pc_i;
            valid_d = 1'b0;
            // A request still in flight must have its response swallowed.
            if ((state_q == WAIT || state_q == DROP) && !imem_resp_i) begin
                state_d = DROP;
            end else begin
                state_d = REQ;
            end
        end else begin
            unique case (state_q)
                REQ:  state_d = WAIT;
                WAIT: begin
                    if (imem_resp_i) begin
                        line_d  = imem_data_i;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!valid_q) begin
                        state_d = REQ;
                    end else if (!fe_stall_i) begin
                        pc_d    = pd_next_pc;
                        valid_d = 1'b0;
                        state_d = REQ;
                    end
                end
                DROP: begin
                    if (imem_resp_i) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_comb begin
        imem_addr_o       = line_base;
        iq_mask_o         = '0;
        iq_entry_o        = '0;
        br_en_o           = 1'b0;
        fetch_pc_offset_o = '0;
        if (offer) begin
            iq_mask_o         = pd_mask;
            br_en_o           = pd_br_en;
            fetch_pc_offset_o = pd_offset;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                iq_entry_o[i].pc = line_base + 32'(4 * i);
                iq_entry_o[i].ir = line_q[32*i +: 32];
                if (pd_offset == OFS_W'(i)) begin
                    iq_entry_o[i].br_predicted = pd_br_predicted;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            line_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            line_q  <= line_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_lines_q, perf_lines_d;
    logic [31:0] perf_redirects_q, perf_redirects_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        perf_lines_d     = perf_lines_q;
        perf_redirects_d = perf_redirects_q;
        perf_stall_d     = perf_stall_q;
        if (iq_enqueue_o && perf_lines_q != '1) begin
            perf_lines_d = perf_lines_q + 32'd1;
        end
        if (((iq_enqueue_o && pd_taken) || fe_flush_i) && perf_redirects_q != '1) begin
            perf_redirects_d = perf_redirects_q + 32'd1;
        end
        if (state_q == HOLD && fe_stall_i && perf_stall_q != '1) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lines_q     <= '0;
            perf_redirects_q <= '0;
            perf_stall_q     <= '0;
        end else begin
            perf_lines_q     <= perf_lines_d;
            perf_redirects_q <= perf_redirects_d;
            perf_stall_q     <= perf_stall_d;
        end
    end

    assign perf_lines_o     = perf_lines_q;
    assign perf_redirects_o = perf_redirects_q;
    assign perf_stall_o     = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_line_unit.sv
// tb/tb_fetch_line_unit.sv - directed bench for fetch_line_unit (8-wide and 4-wide instances)
module tb_fetch_line_unit;
    import rv32cpu_type::*;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] BEQM8 = 32'hFE000CE3; // beq x0,x0,-8
    localparam logic [31:0] JALP64 = 32'h0400006F; // jal x0,+64
    localparam logic [31:0] JAL0 = 32'h0000006F;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                        stall, flush, resp, bp_valid;
    logic [31:0]                 flush_pc;
    logic [1:0]                  bp_cnt;
    logic [255:0]                data;
    logic                        req, enq, br_en;
    logic [31:0]                 addr;
    logic [7:0]                  mask;
    instr_queue_entry_t [7:0]    ent;
    logic [2:0]                  ofs;

    logic                        stall4, resp4;
    logic [127:0]                data4;
    logic                        req4, enq4, br_en4;
    logic [31:0]                 addr4;
    logic [3:0]                  mask4;
    instr_queue_entry_t [3:0]    ent4;
    logic [1:0]                  ofs4;

`ifdef FETCH_PERF_EN
    logic [31:0] p_lines, p_redir, p_stall, p_lines4, p_redir4, p_stall4;
`endif

    int errors = 0;
    int checks = 0;

    fetch_line_unit #(.FETCH_WIDTH(8), .RESET_PC(32'haaaaa000)) u_dut (
        .clk(clk), .rst(rst), .fe_stall_i(stall), .fe_flush_i(flush), .fe_flush_pc_i(flush_pc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_resp_i(resp), .imem_data_i(data),
        .bp_valid_i(bp_valid), .bp_counter_i(bp_cnt), .iq_enqueue_o(enq), .iq_mask_o(mask),
        .iq_entry_o(ent), .br_en_o(br_en), .fetch_pc_offset_o(ofs)
`ifdef FETCH_PERF_EN
        , .perf_lines_o(p_lines), .perf_redirects_o(p_redir), .perf_stall_o(p_stall)
`endif
    );

    fetch_line_unit #(.FETCH_WIDTH(4), .RESET_PC(32'haaaaa000)) u_dut4 (
        .clk(clk), .rst(rst), .fe_stall_i(stall4), .fe_flush_i(1'b0), .fe_flush_pc_i(32'h0),
        .imem_req_o(req4), .imem_addr_o(addr4), .imem_resp_i(resp4), .imem_data_i(data4),
        .bp_valid_i(1'b0), .bp_counter_i(2'b00), .iq_enqueue_o(enq4), .iq_mask_o(mask4),
        .iq_entry_o(ent4), .br_en_o(br_en4), .fetch_pc_offset_o(ofs4)
`ifdef FETCH_PERF_EN
        , .perf_lines_o(p_lines4), .perf_redirects_o(p_redir4), .perf_stall_o(p_stall4)
`endif
    );

    task automatic test_reset;
        @(negedge clk); #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", req); end
        checks++; if (addr !== 32'haaaaa000) begin errors++; $display("FAIL rst_addr: got %h want aaaaa000", addr); end
        checks++; if (enq !== 1'b0) begin errors++; $display("FAIL rst_enq: got %b want 0", enq); end
        checks++; if (mask !== 8'h00) begin errors++; $display("FAIL rst_mask: got %h want 00", mask); end
        checks++; if (br_en !== 1'b0 || ofs !== 3'd0) begin errors++; $display("FAIL rst_br: got %b/%0d want 0/0", br_en, ofs); end
        checks++; if (ent !== '0) begin errors++; $display("FAIL rst_entry: got %h want 0", ent); end
        checks++; if (addr4 !== 32'haaaaa000 || req4 !== 1'b0) begin errors++; $display("FAIL rst_w4: got %h/%b want aaaaa000/0", addr4, req4); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_nop_line;
        #1;
        checks++; if (req !== 1'b1 || addr !== 32'haaaaa000) begin errors++; $display("FAIL nop_req: got %b/%h want 1/aaaaa000", req, addr); end
        @(negedge clk); resp = 1'b1; data = {8{NOP}}; #1;
        checks++; if (enq !== 1'b0) begin errors++; $display("FAIL nop_wait_enq: got %b want 0", enq); end
        @(negedge clk); resp = 1'b0; #1;
        checks++; if (enq !== 1'b1 || mask !== 8'hff) begin errors++; $display("FAIL nop_enq: got %b/%h want 1/ff", enq, mask); end
        checks++; if (ent[0].pc !== 32'haaaaa000 || ent[7].pc !== 32'haaaaa01c) begin errors++; $display("FAIL nop_pcs: got %h/%h want aaaaa000/aaaaa01c", ent[0].pc, ent[7].pc); end
        checks++; if (ent[3].ir !== NOP || br_en !== 1'b0 || ofs !== 3'd0) begin errors++; $display("FAIL nop_ir: got %h/%b/%0d want %h/0/0", ent[3].ir, br_en, ofs, NOP); end
        @(negedge clk); #1;
        checks++; if (req !== 1'b1 || addr !== 32'haaaaa020 || enq !== 1'b0) begin errors++; $display("FAIL nop_next: got %b/%h/%b want 1/aaaaa020/0", req, addr, enq); end
    endtask

    task automatic test_flush_no_cf;
        @(negedge clk); flush = 1'b1; flush_pc = 32'haaaaa014; #1;
        checks++; if (enq !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL fl_cycle: got %b/%b want 0/0", enq, req); end
        @(negedge clk); flush = 1'b0; resp = 1'b1; data = {8{JAL0}}; #1;
        checks++; if (req !== 1'b0 || enq !== 1'b0) begin errors++; $display("FAIL fl_drop: got %b/%b want 0/0", req, enq); end
        @(negedge clk); resp = 1'b0; #1;
        checks++; if (req !== 1'b1 || addr !== 32'haaaaa000) begin errors++; $display("FAIL fl_req: got %b/%h want 1/aaaaa000", req, addr); end
        @(negedge clk); resp = 1'b1; data = {8{NOP}};
        @(negedge clk); resp = 1'b0; #1;
        checks++; if (enq !== 1'b1 || mask !== 8'he0) begin errors++; $display("FAIL fl_mask: got %b/%h want 1/e0", enq, mask); end
        checks++; if (ent[0].pc !== 32'haaaaa000 || ent[5].pc !== 32'haaaaa014) begin errors++; $display("FAIL fl_pcs: got %h/%h want aaaaa000/aaaaa014", ent[0].pc, ent[5].pc); end
        @(negedge clk); #1;
        checks++; if (req !== 1'b1 || addr !== 32'haaaaa020) begin errors++; $display("FAIL fl_next: got %b/%h want 1/aaaaa020", req, addr); end
    endtask

    task automatic test_branch_btfn;
        logic [255:0] d;
        d = {8{NOP}}; d[32*2 +: 32] = BEQM8; d[32*5 +: 32] = JAL0;
        @(negedge clk); flush = 1'b1; flush_pc = 32'haaaaa000; resp = 1'b1; #1;
        checks++; if (enq !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL coinc_cycle: got %b/%b want 0/0", enq, req); end
        @(negedge clk); flush = 1'b0; resp = 1'b0; #1;
        checks++; if (req !== 1'b1 || addr !== 32'haaaaa000) begin errors++; $display("FAIL coinc_req: got %b/%h want 1/aaaaa000", req, addr); end
        @(negedge clk); resp = 1'b1; data = d; bp_valid = 1'b0;
        @(negedge clk); resp = 1'b0; #1;
        checks++; if (enq !== 1'b1 || mask !== 8'h07) begin errors++; $display("FAIL btfn_mask: got %b/%h want 1/07", enq, mask); end
        checks++; if (br_en !== 1'b1 || ofs !== 3'd2) begin errors++; $display("FAIL btfn_slot: got %b/%0d want 1/2", br_en, ofs); end
        checks++; if (ent[2].br_predicted !== 2'b10 || ent[5].br_predicted !== 2'b00) begin errors++; $display("FAIL btfn_pred: got %b/%b want 10/00", ent[2].br_predicted, ent[5].br_predicted); end
        @(negedge clk); #1;
        checks++; if (req !== 1'b1 || addr !== 32'haaaaa000) begin errors++; $display("FAIL btfn_next: got %b/%h want 1/aaaaa000", req, addr); end
    endtask

    task automatic test_branch_counter;
        logic [255:0] d;
        d = {8{NOP}}; d[32*2 +: 32] = BEQM8; d[32*5 +: 32] = JAL0;
        @(negedge clk); resp = 1'b1; data = d; bp_valid = 1'b1; bp_cnt = 2'b01;
        @(negedge clk); resp = 1'b0; #1;
        checks++; if (enq !== 1'b1 || mask !== 8'h07 || br_en !== 1'b1) begin errors++; $display("FAIL cnt_mask: got %b/%h/%b want 1/07/1", enq, mask, br_en); end
        checks++; if (ent[2].br_predicted !== 2'b01) begin errors++; $display("FAIL cnt_pred: got %b want 01", ent[2].br_predicted); end
        @(negedge clk); bp_valid = 1'b0; #1;
        checks++; if (req !== 1'b1 || addr !== 32'haaaaa000) begin errors++; $display("FAIL cnt_next: got %b/%h want 1/aaaaa000", req, addr); end
        @(negedge clk); resp = 1'b1; data = {8{NOP}};
        @(negedge clk); resp = 1'b0; #1;
        checks++; if (enq !== 1'b1 || mask !== 8'hf8 || ent[3].pc !== 32'haaaaa00c) begin errors++; $display("FAIL cnt_fallthru: got %b/%h/%h want 1/f8/aaaaa00c", enq, mask, ent[3].pc); end
        @(negedge clk); #1;
        checks++; if (req !== 1'b1 || addr !== 32'haaaaa020) begin errors++; $display("FAIL cnt_seq: got %b/%h want 1/aaaaa020", req, addr); end
    endtask

    task automatic test_flush_in_wait;
        @(negedge clk); flush = 1'b1; flush_pc = 32'haaaaa104; #1;
        checks++; if (enq !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL fw_cycle: got %b/%b want 0/0", enq, req); end
        @(negedge clk); flush = 1'b0; #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL fw_drop1: got %b want 0", req); end
        @(negedge clk); resp = 1'b1; data = {8{JAL0}}; #1;
        checks++; if (req !== 1'b0 || enq !== 1'b0) begin errors++; $display("FAIL fw_drop2: got %b/%b want 0/0", req, enq); end
        @(negedge clk); resp = 1'b0; #1;
        checks++; if (req !== 1'b1 || addr !== 32'haaaaa100 || enq !== 1'b0) begin errors++; $display("FAIL fw_req: got %b/%h/%b want 1/aaaaa100/0", req, addr, enq); end
    endtask

    task automatic test_jal;
        logic [255:0] d;
        d = {8{NOP}}; d[32*1 +: 32] = JALP64; d[32*3 +: 32] = BEQM8;
        @(negedge clk); resp = 1'b1; data = d;
        @(negedge clk); resp = 1'b0; #1;
        checks++; if (enq !== 1'b1 || mask !== 8'h02) begin errors++; $display("FAIL jal_mask: got %b/%h want 1/02", enq, mask); end
        checks++; if (ofs !== 3'd1 || br_en !== 1'b0 || ent[1].br_predicted !== 2'b00) begin errors++; $display("FAIL jal_slot: got %0d/%b/%b want 1/0/00", ofs, br_en, ent[1].br_predicted); end
        @(negedge clk); #1;
        checks++; if (req !== 1'b1 || addr !== 32'haaaaa140) begin errors++; $display("FAIL jal_next: got %b/%h want 1/aaaaa140", req, addr); end
    endtask

    task automatic test_stall;
        @(negedge clk); resp = 1'b1; data = {8{NOP}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); resp = 1'b0; stall = 1'b1; #1;
            checks++; if (enq !== 1'b0 || req !== 1'b0 || mask !== 8'hfe || ent[1].pc !== 32'haaaaa144) begin
                errors++; $display("FAIL stall_hold%0d: got %b/%b/%h/%h want 0/0/fe/aaaaa144", i, enq, req, mask, ent[1].pc);
            end
        end
        @(negedge clk); stall = 1'b0; #1;
        checks++; if (enq !== 1'b1 || mask !== 8'hfe) begin errors++; $display("FAIL stall_release: got %b/%h want 1/fe", enq, mask); end
        @(negedge clk); #1;
        checks++; if (enq !== 1'b0 || req !== 1'b1 || addr !== 32'haaaaa160) begin errors++; $display("FAIL stall_next: got %b/%b/%h want 0/1/aaaaa160", enq, req, addr); end
    endtask

    task automatic test_w4_stall;
        @(negedge clk); resp4 = 1'b1; data4 = {4{NOP}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); resp4 = 1'b0; stall4 = 1'b1; #1;
            checks++; if (enq4 !== 1'b0 || req4 !== 1'b0 || mask4 !== 4'hf) begin
                errors++; $display("FAIL w4_hold%0d: got %b/%b/%h want 0/0/f", i, enq4, req4, mask4);
            end
        end
        @(negedge clk); stall4 = 1'b0; #1;
        checks++; if (enq4 !== 1'b1 || mask4 !== 4'hf || ent4[3].pc !== 32'haaaaa00c) begin errors++; $display("FAIL w4_release: got %b/%h/%h want 1/f/aaaaa00c", enq4, mask4, ent4[3].pc); end
        @(negedge clk); #1;
        checks++; if (req4 !== 1'b1 || addr4 !== 32'haaaaa010 || enq4 !== 1'b0) begin errors++; $display("FAIL w4_next: got %b/%h/%b want 1/aaaaa010/0", req4, addr4, enq4); end
`ifdef FETCH_PERF_EN
        checks++; if (p_stall4 !== 32'd5 || p_lines4 !== 32'd1 || p_redir4 !== 32'd0) begin errors++; $display("FAIL w4_perf: got %0d/%0d/%0d want 5/1/0", p_stall4, p_lines4, p_redir4); end
        checks++; if (p_stall !== 32'd5 || p_lines !== 32'd7 || p_redir !== 32'd5) begin errors++; $display("FAIL w8_perf: got %0d/%0d/%0d want 5/7/5", p_stall, p_lines, p_redir); end
`endif
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = '0; resp = 1'b0; data = '0;
        bp_valid = 1'b0; bp_cnt = 2'b00; stall4 = 1'b0; resp4 = 1'b0; data4 = '0;
        test_reset;
        test_nop_line;
        test_flush_no_cf;
        test_branch_btfn;
        test_branch_counter;
        test_flush_in_wait;
        test_jal;
        test_stall;
        test_w4_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
